cameralink_frame_scheduler: RTL

CAMERALINK_FRAME_SCHEDULER -- requirements
Module: cameralink_frame_scheduler

---
 rtl/cameralink_pkg.sv | 35 +++
 rtl/cl_valid_delay.sv | 33 +++
 rtl/cameralink_frame_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cameralink_pkg.sv
// Shared definitions for the CameraLink frame scheduler.
//   - state_e    : scheduler FSM states
//   - cfg_t      : latched frame geometry (width, height, blanking)
//   - CNT_W      : width of every pixel/line/blanking count
//   - RD_LAT_MIN/RD_LAT_MAX : legal range of the FIFO read latency
//   - at_least_one() : blanking length with zero promoted to one cycle
package cameralink_pkg;

  localparam int CNT_W      = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic [2:0] {
    IDLE,
    FV_LEAD,
    WAIT_LINE,
    LINE,
    HBLANK,
    VBLANK
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] w;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] hblank;
    logic [CNT_W-1:0] vblank;
  } cfg_t;

  // A blanking period of zero still costs one cycle so the FSM always
  // passes through the blanking state.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/cl_valid_delay.sv
// Fixed-depth register pipeline used to align the CameraLink valid strobes
// (and, in test-pattern builds, the pattern data) with the FIFO read latency.
// Ports:
//   cm_data_clk : clock, rising edge
//   rst         : synchronous active-high reset, clears every stage
//   d           : WIDTH-bit input
//   q           : d delayed by exactly DEPTH cycles
module cl_valid_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             cm_data_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // NOTE: this array is cleared on reset on purpose: a stale valid bit left in
  // the pipeline would appear on the CameraLink outputs after rst is released.
  always_ff @(posedge cm_data_clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/cameralink_frame_scheduler.sv
// CameraLink frame scheduler: paces line reads out of a pixel FIFO and
// generates frame/line/data valid strobes with programmable geometry.
//
// Optional feature: define CL_TEST_PATTERN_EN to add a test-pattern mode
// (input tp_en, output tp_data). With tp_en=1 the FIFO is never read, lines
// start without waiting for FIFO fill, and tp_data = pixel + line count.
//
// Ports:
//   cm_data_clk, rst        : clock / synchronous active-high reset
//   cfg_image_w/h           : pixels per line / lines per frame
//   cfg_hblank/vblank       : idle cycles between lines / after a frame
//   start                   : one-cycle frame request (ignored while busy)
//   cont_mode               : restart automatically after each frame
//   stop_req                : finish current frame, then go idle
//   fifo_count, fifo_empty  : line FIFO status
//   fifo_rd_en              : FIFO read strobe, one per pixel
//   cm_frame/line/data_valid: raw valids delayed by RD_LAT cycles
//   busy                    : scheduler active (not IDLE)
//   frame_done              : pulse on the first vertical-blank cycle
//   cfg_err                 : pulse when a start carries zero width/height
//   underrun                : sticky, read attempted while FIFO empty
module cameralink_frame_scheduler
  import cameralink_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int FV_SETUP = 2
) (
  input  logic             cm_data_clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_image_w,
  input  logic [CNT_W-1:0] cfg_image_h,
  input  logic [CNT_W-1:0] cfg_hblank,
  input  logic [CNT_W-1:0] cfg_vblank,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             stop_req,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             fifo_empty,
`ifdef CL_TEST_PATTERN_EN
  input  logic             tp_en,
  output logic [CNT_W-1:0] tp_data,
`endif
  output logic             fifo_rd_en,
  output logic             cm_frame_valid,
  output logic             cm_line_valid,
  output logic             cm_data_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic             underrun
);

  // Out-of-range parameters are clamped to the nearest legal value.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int FV_CYC = (FV_SETUP < 1) ? 1 : FV_SETUP;
  localparam logic [CNT_W-1:0] FV_LAST = CNT_W'(FV_CYC - 1);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_in;
  logic [CNT_W-1:0] tmr_q;
  logic [CNT_W-1:0] pix_q;
  logic [CNT_W-1:0] line_q;
  logic             stop_pend_q;
  logic             underrun_q;
  logic             cfg_err_q, cfg_err_d;
  logic             latch_cfg;

  logic cfg_ok, tp_mode, line_ready, line_active;
  logic fv_done, hb_done, vb_done, last_pix, last_line, keep_running;
  logic raw_fv, raw_lv, raw_dv;

  assign cfg_in = '{w: cfg_image_w, h: cfg_image_h,
                    hblank: cfg_hblank, vblank: cfg_vblank};
  assign cfg_ok = (cfg_image_w != '0) && (cfg_image_h != '0);

`ifdef CL_TEST_PATTERN_EN
  assign tp_mode = tp_en;
`else
  assign tp_mode = 1'b0;
`endif

  // Ready to emit a whole line: the FIFO already holds w words (or the
  // pattern generator is the source and needs no FIFO data).
  assign line_ready = tp_mode || (fifo_count >= cfg_q.w);

  // tmr_q restarts at zero on every state change, so it is the cycle index
  // within the current FV_LEAD / HBLANK / VBLANK period.
  assign fv_done   = (tmr_q == FV_LAST);
  assign hb_done   = (tmr_q == at_least_one(cfg_q.hblank) - 1'b1);
  assign vb_done   = (tmr_q == at_least_one(cfg_q.vblank) - 1'b1);
  assign last_pix  = (pix_q == cfg_q.w - 1'b1);
  assign last_line = (line_q == cfg_q.h - 1'b1);

  // The current-cycle stop_req is included so a stop arriving on the very
  // last blanking cycle still prevents the restart.
  assign keep_running = cont_mode && !(stop_pend_q || stop_req);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch
    // is inferred.
    state_d   = state_q;
    latch_cfg = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            latch_cfg = 1'b1;
            state_d   = FV_LEAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      // A ready line skips WAIT_LINE entirely, so a full FIFO costs no
      // extra cycle between frame-valid lead / hblank and the line.
      FV_LEAD: begin
        if (fv_done) state_d = line_ready ? LINE : WAIT_LINE;
      end
      WAIT_LINE: begin
        if (line_ready) state_d = LINE;
      end
      LINE: begin
        if (last_pix) state_d = last_line ? VBLANK : HBLANK;
      end
      HBLANK: begin
        if (hb_done) state_d = line_ready ? LINE : WAIT_LINE;
      end
      VBLANK: begin
        if (vb_done) begin
          state_d = IDLE;
          if (keep_running) begin
            // A restart re-latches the geometry; invalid geometry is
            // reported the same way as a bad start and the block idles.
            if (cfg_ok) begin
              latch_cfg = 1'b1;
              state_d   = FV_LEAD;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, counters and flags
  // ---------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge cm_data_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      tmr_q       <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      stop_pend_q <= 1'b0;
      underrun_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;

      if (latch_cfg) cfg_q <= cfg_in;

      tmr_q <= (state_d != state_q) ? '0 : tmr_q + 1'b1;

      if (state_q == LINE) begin
        pix_q <= last_pix ? '0 : pix_q + 1'b1;
        if (last_pix) line_q <= last_line ? '0 : line_q + 1'b1;
      end else begin
        pix_q <= '0;
        if (state_q == IDLE) line_q <= '0;
      end

      if (state_d == IDLE && state_q != IDLE) stop_pend_q <= 1'b0;
      else if (busy && stop_req)              stop_pend_q <= 1'b1;

      // An accepted start happens in IDLE where no read is possible, so
      // the clear and the set can never collide.
      if (latch_cfg && state_q == IDLE)  underrun_q <= 1'b0;
      else if (fifo_rd_en && fifo_empty) underrun_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign line_active = (state_q == LINE);
  assign fifo_rd_en  = line_active && !tp_mode;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == VBLANK) && (tmr_q == '0);
  assign cfg_err     = cfg_err_q;
  assign underrun    = underrun_q;

  assign raw_fv = (state_q == FV_LEAD) || (state_q == WAIT_LINE) ||
                  (state_q == LINE)    || (state_q == HBLANK);
`ifdef CL_TEST_PATTERN_EN
  // In pattern mode the line still runs without FIFO reads, so the line/
  // data valids follow the LINE state rather than the read strobe.
  assign raw_lv = line_active;
  assign raw_dv = line_active;

  logic [CNT_W-1:0] tp_raw;
  assign tp_raw = pix_q + line_q;

  cl_valid_delay #(.DEPTH(LAT), .WIDTH(CNT_W)) u_tp_delay (
    .cm_data_clk (cm_data_clk),
    .rst         (rst),
    .d           (tp_raw),
    .q           (tp_data)
  );
`else
  assign raw_lv = fifo_rd_en;
  assign raw_dv = fifo_rd_en;
`endif

  cl_valid_delay #(.DEPTH(LAT), .WIDTH(3)) u_valid_delay (
    .cm_data_clk (cm_data_clk),
    .rst         (rst),
    .d           ({raw_fv, raw_lv, raw_dv}),
    .q           ({cm_frame_valid, cm_line_valid, cm_data_valid})
  );

endmodule
